// File: rtl/jtag_scan_engine.sv
// JTAG scan engine: selects one of NUM_TARGETS chains and shifts up to 32 TMS/TDI
// bit pairs at a divided TCK rate, capturing TDO on each TCK rising edge.
//
// state  | meaning
// IDLE   | waiting for START; illegal requests pulse ERR
// SETUP  | mux select settling, CLK_DIV cycles with TCK low
// LOW    | TCK low half-period, TMS/TDI driven for the current bit
// HIGH   | TCK high half-period, TDO captured on entry
// FINISH | one-cycle DONE; also accepts a back-to-back START
module jtag_scan_engine #(
    parameter int          CLK_DIV     = 4,
    parameter int unsigned NUM_TARGETS = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  target_i,
    input  logic [5:0]  nbits_i,
    input  logic [31:0] tms_vec_i,
    input  logic [31:0] tdi_vec_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] tdo_vec_o,
    output logic [3:0]  jtag_sel_o,
    output logic        v_tck_o,
    output logic        v_tms_o,
    output logic        v_tdi_o,
    input  logic        v_tdo_i
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_FINISH} state_t;

    if ((CLK_DIV < 1) || (CLK_DIV > 255)) begin : g_bad_clk_div
        $error("jtag_scan_engine: CLK_DIV must be within 1..255");
    end

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [5:0]  nbits_q, nbits_d;
    logic [31:0] tms_vec_q, tms_vec_d;
    logic [31:0] tdi_vec_q, tdi_vec_d;
    logic [31:0] tdo_q, tdo_d;
    logic [3:0]  sel_q, sel_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        tck_q, tck_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;

    logic req_ok;
    logic phase_end;
    logic last_bit;

    assign req_ok    = ({28'd0, target_i} < NUM_TARGETS) && (nbits_i != 6'd0) && (nbits_i <= 6'd32);
    assign phase_end = (cnt_q == 8'd0);
    assign last_bit  = ({1'b0, bit_q} == (nbits_q - 6'd1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            bit_q     <= 5'd0;
            nbits_q   <= 6'd0;
            tms_vec_q <= 32'd0;
            tdi_vec_q <= 32'd0;
            tdo_q     <= 32'd0;
            sel_q     <= 4'hF;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tck_q     <= 1'b0;
            tms_q     <= 1'b1;
            tdi_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            nbits_q   <= nbits_d;
            tms_vec_q <= tms_vec_d;
            tdi_vec_q <= tdi_vec_d;
            tdo_q     <= tdo_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tck_q     <= tck_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        nbits_d   = nbits_q;
        tms_vec_d = tms_vec_q;
        tdi_vec_d = tdi_vec_q;
        tdo_d     = tdo_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tck_d     = tck_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;

        case (state_q)
            S_IDLE, S_FINISH: begin
                state_d = S_IDLE;
                if (start_i) begin
                    if (req_ok) begin
                        state_d   = S_SETUP;
                        cnt_d     = DIV_LAST;
                        bit_d     = 5'd0;
                        nbits_d   = nbits_i;
                        tms_vec_d = tms_vec_i;
                        tdi_vec_d = tdi_vec_i;
                        tdo_d     = 32'd0;
                        sel_d     = target_i;
                        busy_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    state_d = S_LOW;
                    cnt_d   = DIV_LAST;
                    tms_d   = tms_vec_q[bit_q];
                    tdi_d   = tdi_vec_q[bit_q];
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_LOW: begin
                if (phase_end) begin
                    state_d       = S_HIGH;
                    cnt_d         = DIV_LAST;
                    tck_d         = 1'b1;
                    tdo_d[bit_q]  = v_tdo_i;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    tck_d = 1'b0;
                    cnt_d = DIV_LAST;
                    if (last_bit) begin
                        // TMS is left as-is so the TAP stays parked in its final state
                        state_d = S_FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tdi_d   = 1'b0;
                    end else begin
                        state_d = S_LOW;
                        bit_d   = bit_q + 5'd1;
                        tms_d   = tms_vec_q[bit_q + 5'd1];
                        tdi_d   = tdi_vec_q[bit_q + 5'd1];
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign tdo_vec_o  = tdo_q;
    assign jtag_sel_o = sel_q;
    assign v_tck_o    = tck_q;
    assign v_tms_o    = tms_q;
    assign v_tdi_o    = tdi_q;

endmodule
